cse_x25_axilite_master: RTL and testbench

CSE_X25_AXILITE_MASTER -- requirements
Module: cse_x25_axilite_master

---
 rtl/cse_x25_axilite_master.sv | 165 ++++++++++++++++
 tb/tb_cse_x25_axilite_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cse_x25_axilite_master.sv
// Single-outstanding AXI-Lite master: turns a simple valid/ready request into one
// AXI-Lite write or read, then returns the captured response on a valid/ready port.
module cse_x25_axilite_master #(
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [axi_addr_width_p-1:0] req_addr_i,
  input  logic [axi_data_width_p-1:0] req_data_i,

  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [axi_data_width_p-1:0] rsp_data_o,
  output logic [1:0]                  rsp_resp_o,
  output logic                        rsp_err_o,
  output logic                        rsp_we_o,

  output logic [axi_addr_width_p-1:0] axi_awaddr_o,
  output logic                        axi_awvalid_o,
  input  logic                        axi_awready_i,
  output logic [axi_data_width_p-1:0] axi_wdata_o,
  output logic                        axi_wvalid_o,
  input  logic                        axi_wready_i,
  input  logic [1:0]                  axi_bresp_i,
  input  logic                        axi_bvalid_i,
  output logic                        axi_bready_o,
  output logic [axi_addr_width_p-1:0] axi_araddr_o,
  output logic                        axi_arvalid_o,
  input  logic                        axi_arready_i,
  input  logic [axi_data_width_p-1:0] axi_rdata_i,
  input  logic [1:0]                  axi_rresp_i,
  input  logic                        axi_rvalid_i,
  output logic                        axi_rready_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_e;

  state_e                      state_q, state_d;
  logic                        we_q, we_d;
  logic [axi_addr_width_p-1:0] addr_q, addr_d;
  logic [axi_data_width_p-1:0] wdata_q, wdata_d;
  logic                        aw_pend_q, aw_pend_d;
  logic                        w_pend_q, w_pend_d;
  logic [axi_data_width_p-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]                  rsp_resp_q, rsp_resp_d;
  logic                        aw_done, w_done;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    aw_pend_d     = aw_pend_q;
    w_pend_d      = w_pend_q;
    rsp_data_d    = rsp_data_q;
    rsp_resp_d    = rsp_resp_q;
    req_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_bready_o  = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;
    aw_done       = 1'b0;
    w_done        = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = !reset_i;
        if (req_valid_i) begin
          we_d      = req_we_i;
          addr_d    = req_addr_i;
          wdata_d   = req_we_i ? req_data_i : '0;
          aw_pend_d = req_we_i;
          w_pend_d  = req_we_i;
          state_d   = req_we_i ? WR_ADDR_DATA : RD_ADDR;
        end
      end

      // AW and W complete independently; each pending flag drops after its own handshake.
      WR_ADDR_DATA: begin
        axi_awvalid_o = aw_pend_q;
        axi_wvalid_o  = w_pend_q;
        aw_done       = !aw_pend_q || axi_awready_i;
        w_done        = !w_pend_q || axi_wready_i;
        if (aw_pend_q && axi_awready_i) aw_pend_d = 1'b0;
        if (w_pend_q && axi_wready_i)   w_pend_d  = 1'b0;
        if (aw_done && w_done) state_d = WR_RESP;
      end

      WR_RESP: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) begin
          rsp_resp_d = axi_bresp_i;
          rsp_data_d = '0;
          state_d    = RESP;
        end
      end

      RD_ADDR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) state_d = RD_DATA;
      end

      RD_DATA: begin
        axi_rready_o = 1'b1;
        if (axi_rvalid_i) begin
          rsp_data_d = axi_rdata_i;
          rsp_resp_d = axi_rresp_i;
          state_d    = RESP;
        end
      end

      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign axi_awaddr_o = addr_q;
  assign axi_araddr_o = addr_q;
  assign axi_wdata_o  = wdata_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_resp_o   = rsp_resp_q;
  assign rsp_err_o    = rsp_resp_q[1];
  assign rsp_we_o     = we_q;

endmodule

// File: tb/tb_cse_x25_axilite_master.sv
// Directed bench for cse_x25_axilite_master with a small behavioural AXI-Lite slave
// whose AW stall length and RRESP value are set per step.
module tb_cse_x25_axilite_master;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_data_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [1:0]  rsp_resp_o;
  logic        rsp_err_o, rsp_we_o;
  logic [31:0] axi_awaddr_o, axi_wdata_o, axi_araddr_o, axi_rdata_i;
  logic        axi_awvalid_o, axi_awready_i, axi_wvalid_o, axi_wready_i;
  logic [1:0]  axi_bresp_i, axi_rresp_i;
  logic        axi_bvalid_i, axi_bready_o, axi_arvalid_o, axi_arready_i;
  logic        axi_rvalid_i, axi_rready_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  cse_x25_axilite_master dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_resp_o(rsp_resp_o), .rsp_err_o(rsp_err_o), .rsp_we_o(rsp_we_o),
    .axi_awaddr_o(axi_awaddr_o), .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
    .axi_araddr_o(axi_araddr_o), .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i), .axi_rvalid_i(axi_rvalid_i),
    .axi_rready_o(axi_rready_o)
  );

  // Behavioural slave: B one cycle after both AW and W, R one cycle after AR.
  int          aw_stall_cfg;
  logic [1:0]  rresp_cfg;
  int          aw_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, w_data_l;
  logic [31:0] mem [0:15];

  assign axi_awready_i = (aw_cnt >= aw_stall_cfg);
  assign axi_wready_i  = 1'b1;
  assign axi_arready_i = 1'b1;

  always @(posedge clk_i) begin
    if (reset_i) begin
      aw_cnt       <= 0;
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      axi_bvalid_i <= 1'b0;
      axi_bresp_i  <= 2'b00;
      axi_rvalid_i <= 1'b0;
      axi_rresp_i  <= 2'b00;
      axi_rdata_i  <= 32'h0;
    end else begin
      if (axi_awvalid_o && !axi_awready_i) aw_cnt <= aw_cnt + 1;
      if (axi_awvalid_o && axi_awready_i) begin
        aw_cnt    <= 0;
        aw_got    <= 1'b1;
        aw_addr_l <= axi_awaddr_o;
      end
      if (axi_wvalid_o && axi_wready_i) begin
        w_got    <= 1'b1;
        w_data_l <= axi_wdata_o;
      end
      if ((aw_got || (axi_awvalid_o && axi_awready_i)) &&
          (w_got || (axi_wvalid_o && axi_wready_i)) && !axi_bvalid_i) begin
        mem[aw_got ? aw_addr_l[5:2] : axi_awaddr_o[5:2]] <= w_got ? w_data_l : axi_wdata_o;
        axi_bvalid_i <= 1'b1;
        axi_bresp_i  <= 2'b00;
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
      end
      if (axi_bvalid_i && axi_bready_o) axi_bvalid_i <= 1'b0;
      if (axi_arvalid_o && axi_arready_i) begin
        axi_rvalid_i <= 1'b1;
        axi_rdata_i  <= mem[axi_araddr_o[5:2]];
        axi_rresp_i  <= rresp_cfg;
      end
      if (axi_rvalid_i && axi_rready_o) axi_rvalid_i <= 1'b0;
    end
  end

  // Per-cycle logs after an accept: bit c holds the value seen in cycle c.
  logic [11:0] awv_log, wv_log, brdy_log, arv_log, rrdy_log, rspv_log, rqr_log;
  int          addr_bad, rsp_unstable;
  logic        got_rsp;
  logic [31:0] rsp_data_seen, last_addr, last_data;
  logic [1:0]  resp_seen;
  logic        we_seen, err_seen;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_data_i  = data;
    last_addr   = addr;
    last_data   = data;
    @(negedge clk_i);
    checkOutput("req_ready_at_accept", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_addr_i  = 32'hFFFF_FFFF;
    req_data_i  = 32'h0BAD_0BAD;
  endtask

  task automatic recordCycles(input int rsp_rise_at, input int reset_at);
    awv_log = '0; wv_log = '0; brdy_log = '0; arv_log = '0;
    rrdy_log = '0; rspv_log = '0; rqr_log = '0;
    addr_bad = 0; rsp_unstable = 0; got_rsp = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk_i);
      awv_log[c]  = axi_awvalid_o;
      wv_log[c]   = axi_wvalid_o;
      brdy_log[c] = axi_bready_o;
      arv_log[c]  = axi_arvalid_o;
      rrdy_log[c] = axi_rready_o;
      rspv_log[c] = rsp_valid_o;
      rqr_log[c]  = req_ready_o;
      if ((axi_awvalid_o && axi_awaddr_o !== last_addr) ||
          (axi_arvalid_o && axi_araddr_o !== last_addr) ||
          (axi_wvalid_o && axi_wdata_o !== last_data)) addr_bad++;
      if (rsp_valid_o && !got_rsp) begin
        got_rsp       = 1'b1;
        rsp_data_seen = rsp_data_o;
        resp_seen     = rsp_resp_o;
        we_seen       = rsp_we_o;
        err_seen      = rsp_err_o;
      end else if (rsp_valid_o) begin
        if (rsp_data_o !== rsp_data_seen || rsp_resp_o !== resp_seen) rsp_unstable++;
      end
      if (c == rsp_rise_at) rsp_ready_i = 1'b1;
      if (c == reset_at) reset_i = 1'b1;
      if (reset_at != 0 && c == reset_at + 1) reset_i = 1'b0;
    end
  endtask

  initial begin
    reset_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = 32'h0; req_data_i = 32'h0; rsp_ready_i = 1'b1;
    aw_stall_cfg = 0; rresp_cfg = 2'b00;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("req_ready_in_reset", {31'b0, req_ready_o}, 32'd0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_req_ready", {31'b0, req_ready_o}, 32'd1);
    checkOutput("reset_axi_handshakes",
                {27'b0, axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o}, 32'd0);
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("reset_rsp_fields", {rsp_data_o[28:0], rsp_resp_o, rsp_we_o}, 32'd0);

    // Zero-wait write of 0xDEADBEEF to 0x10.
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF);
    recordCycles(0, 0);
    checkOutput("wr_awvalid_cycles", {20'b0, awv_log}, 32'h002);
    checkOutput("wr_wvalid_cycles", {20'b0, wv_log}, 32'h002);
    checkOutput("wr_bready_cycles", {20'b0, brdy_log}, 32'h004);
    checkOutput("wr_rsp_valid_cycles", {20'b0, rspv_log}, 32'h008);
    checkOutput("wr_req_ready_cycles", {20'b0, rqr_log}, 32'hFF0);
    checkOutput("wr_rsp_we", {31'b0, we_seen}, 32'd1);
    checkOutput("wr_rsp_resp", {30'b0, resp_seen}, 32'd0);
    checkOutput("wr_rsp_data", rsp_data_seen, 32'h0);
    checkOutput("wr_axi_addr_data", addr_bad, 32'd0);

    // Zero-wait read of 0x10.
    applyStimulus(1'b0, 32'h10, 32'h0);
    recordCycles(0, 0);
    checkOutput("rd_arvalid_cycles", {20'b0, arv_log}, 32'h002);
    checkOutput("rd_rready_cycles", {20'b0, rrdy_log}, 32'h004);
    checkOutput("rd_rsp_valid_cycles", {20'b0, rspv_log}, 32'h008);
    checkOutput("rd_rsp_data", rsp_data_seen, 32'hDEAD_BEEF);
    checkOutput("rd_rsp_err", {31'b0, err_seen}, 32'd0);
    checkOutput("rd_rsp_we", {31'b0, we_seen}, 32'd0);
    checkOutput("rd_axi_addr", addr_bad, 32'd0);

    // AW stalled three cycles, W accepted immediately.
    aw_stall_cfg = 3;
    applyStimulus(1'b1, 32'h10, 32'h1234_5678);
    recordCycles(0, 0);
    aw_stall_cfg = 0;
    checkOutput("stall_awvalid_cycles", {20'b0, awv_log}, 32'h01E);
    checkOutput("stall_wvalid_cycles", {20'b0, wv_log}, 32'h002);
    checkOutput("stall_bready_cycles", {20'b0, brdy_log}, 32'h020);
    checkOutput("stall_rsp_valid_cycles", {20'b0, rspv_log}, 32'h040);
    checkOutput("stall_req_ready_cycles", {20'b0, rqr_log}, 32'hF80);
    checkOutput("stall_awaddr_held", addr_bad, 32'd0);

    // Response held off for five cycles in RESP.
    rsp_ready_i = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0);
    recordCycles(8, 0);
    checkOutput("hold_rsp_valid_cycles", {20'b0, rspv_log}, 32'h1F8);
    checkOutput("hold_req_ready_cycles", {20'b0, rqr_log}, 32'hE00);
    checkOutput("hold_axi_valid_cycles", {20'b0, awv_log | wv_log | arv_log}, 32'h002);
    checkOutput("hold_rsp_stable", rsp_unstable, 32'd0);
    checkOutput("hold_rsp_data", rsp_data_seen, 32'h1234_5678);

    // One-cycle reset while waiting in RD_DATA.
    applyStimulus(1'b0, 32'h10, 32'h0);
    recordCycles(0, 2);
    checkOutput("rst_arvalid_cycles", {20'b0, arv_log}, 32'h002);
    checkOutput("rst_rready_cycles", {20'b0, rrdy_log}, 32'h004);
    checkOutput("rst_other_handshakes", {20'b0, awv_log | wv_log | brdy_log}, 32'h000);
    checkOutput("rst_no_rsp_valid", {20'b0, rspv_log}, 32'h000);
    checkOutput("rst_req_ready_cycles", {20'b0, rqr_log}, 32'hFF0);
    checkOutput("rst_rsp_data_cleared", rsp_data_o, 32'h0);

    // Slave returns SLVERR on a read.
    rresp_cfg = 2'b10;
    applyStimulus(1'b0, 32'h10, 32'h0);
    recordCycles(0, 0);
    rresp_cfg = 2'b00;
    checkOutput("err_rsp_valid_cycles", {20'b0, rspv_log}, 32'h008);
    checkOutput("err_rsp_resp", {30'b0, resp_seen}, 32'h2);
    checkOutput("err_rsp_err", {31'b0, err_seen}, 32'd1);
    checkOutput("err_rsp_data", rsp_data_seen, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
